reg_bank: RTL and testbench
===========================

# reg_bank

Parametrised register bank: `DEPTH` words of `WIDTH` bits, one write port and two registered read ports, with a one-deep shadow bank for single-cycle save/restore of the whole bank. It is the datapath register file for the next-generation core and replaces per-register instances. Typical uses are operand fetch and context save on interrupt entry/exit. Reads are write-first, so a value written in cycle N is visible on the read outputs after the cycle-N edge.

## Interface
- `WIDTH`, 16, data width of each register
- `DEPTH`, 16, number of registers; any value ≥2, need not be a power of two
- `ZERO_REG`, 1, when 1, register 0 always reads 0 and ignores writes
- `AW` (localparam), `$clog2(DEPTH)`, address width
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clk`
- `writeReg`  in  1  write enable
- `writeAddr`  in  AW  write address
- `writeData`  in  WIDTH  write data
- `readAddrA`  in  AW  read port A address
- `readAddrB`  in  AW  read port B address
- `save`  in  1  copy the bank into the shadow
- `restore`  in  1  copy the shadow into the bank
- `outDataA`  out  WIDTH  registered read data, port A
- `outDataB`  out  WIDTH  registered read data, port B
- `shadowValid`  out  1  shadow holds an unrestored snapshot

## Operation
Reset:
- `reset`=0 at an edge clears all bank registers, all shadow registers, `outDataA`, `outDataB` and `shadowValid` to 0.
- Reset overrides every other input in that cycle.
- Outputs change only at edges. There is no asynchronous path.

Next-bank computation, per edge, in this order:
1. Base: if `restore`=1 and `shadowValid`=1, the base is the shadow contents. Otherwise the base is the current bank.
2. Write merge: if `writeReg`=1, `writeAddr` < `DEPTH`, and not (`ZERO_REG`=1 and `writeAddr`=0), then `writeData` replaces the base word at `writeAddr`.
3. The result is the next bank.

Write rules:
- A write is applied on top of a same-cycle restore, so the write wins at its address.
- Writes with `writeAddr` ≥ `DEPTH` are ignored.

Read ports:
- Each port registers the next-bank word at its address: `outDataX` ← nextBank[`readAddrX`].
- This gives write-first bypass, and restore-first when a restore is in the same cycle.
- Reading address ≥ `DEPTH` returns 0.
- When `ZERO_REG`=1, reading address 0 returns 0.
- Both ports may read the same address.

Shadow:
- `save`=1 without `restore`: shadow ← next bank, including that cycle's write. `shadowValid` ← 1. A second save overwrites the snapshot.
- `restore`=1 with `shadowValid`=1: the bank is reloaded as above and `shadowValid` ← 0. The shadow contents are left unchanged.
- `restore`=1 with `shadowValid`=0: the restore is a no-op. The write and reads proceed normally.
- `save`=1 and `restore`=1 in the same cycle: restore takes priority, save is ignored, and `shadowValid` ends at 0.

## Timing
- Write latency: 1 edge. Written data is in the bank after the edge where `writeReg`=1.
- Read latency: 1 edge from address to `outDataX`.
- Same-cycle write and read of the same address returns the new data at that same edge.
- Save and restore each take one edge. The whole bank moves in parallel with no stall and no busy signal.
- Reset is effective at the first edge where `reset`=0.
- A reset during back-to-back save/restore discards the snapshot: `shadowValid`=0 after that edge.
- No combinational path from any input to any output.

## Test plan
- **Reset:** write 0xBEEF to r3, then hold `reset`=0 for 1 edge, then read r3 on A and r15 on B → both outputs 0x0000 and `shadowValid`=0.
- **Write/read bypass:** in one cycle write r5←0x1234 with `readAddrA`=5 and `readAddrB`=5 → after that edge both outputs are 0x1234. Write r0←0xFFFF with `ZERO_REG`=1, then read r0 → 0x0000.
- **Save/restore:**
  - Load r1=0x0011 and r2=0x0022.
  - Assert `save` while writing r2←0x00AA → `shadowValid`=1.
  - Overwrite r1←0x9999.
  - Assert `restore` with `readAddrA`=1 → `outDataA`=0x0011 at that edge and `shadowValid`=0.
  - Read r2 → 0x00AA.
- **Restore with same-cycle write:** with shadow r4=0x0044, assert `restore` and write r4←0x7777 in the same cycle → r4 reads 0x7777, and other registers return their shadow values.
- **Invalid and conflicting commands:** assert `restore` with `shadowValid`=0 → bank unchanged. Assert `save` and `restore` in the same cycle with a valid shadow → bank restored and `shadowValid`=0.
- **Non-power-of-two depth:** with `DEPTH`=12, write address 13←0x5555, then read address 13 → 0x0000, and r0–r11 are unchanged.

Source files
------------

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register file with one write port, two registered
// write-first read ports and a one-deep shadow bank for whole-bank
// save/restore in a single cycle.
module reg_bank #(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 16,
  parameter  bit ZERO_REG = 1'b1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeReg,
  input  logic [AW-1:0]    writeAddr,
  input  logic [WIDTH-1:0] writeData,
  input  logic [AW-1:0]    readAddrA,
  input  logic [AW-1:0]    readAddrB,
  input  logic             save,
  input  logic             restore,
  output logic [WIDTH-1:0] outDataA,
  output logic [WIDTH-1:0] outDataB,
  output logic             shadowValid
);

  logic [WIDTH-1:0] bank_q   [DEPTH];
  logic [WIDTH-1:0] bank_d   [DEPTH];
  logic [WIDTH-1:0] shadow_q [DEPTH];
  logic [WIDTH-1:0] shadow_d [DEPTH];
  logic [WIDTH-1:0] outA_q, outA_d;
  logic [WIDTH-1:0] outB_q, outB_d;
  logic             svld_q, svld_d;
  logic             do_restore;

  // Next bank: pick the restore base, then merge the write on top of it.
  always_comb begin
    do_restore = restore & svld_q;
    for (int i = 0; i < DEPTH; i++) begin
      bank_d[i] = do_restore ? shadow_q[i] : bank_q[i];
      if (writeReg && (int'(writeAddr) == i) && !(ZERO_REG && (i == 0)))
        bank_d[i] = writeData;
    end
  end

  // Read muxes look at the next bank, giving write-first and restore-first
  // behaviour; unmatched (out-of-range) addresses and r0 under ZERO_REG give 0.
  always_comb begin
    outA_d = '0;
    outB_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(ZERO_REG && (i == 0))) begin
        if (int'(readAddrA) == i) outA_d = bank_d[i];
        if (int'(readAddrB) == i) outB_d = bank_d[i];
      end
    end
  end

  // Shadow update: restore wins over save; a plain save snapshots the next bank.
  always_comb begin
    shadow_d = shadow_q;
    svld_d   = svld_q;
    if (restore) begin
      svld_d = 1'b0;
    end else if (save) begin
      shadow_d = bank_d;
      svld_d   = 1'b1;
    end
  end

  // State registers with synchronous active-low clear of bank, shadow and outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      outA_q <= '0;
      outB_q <= '0;
      svld_q <= 1'b0;
    end else begin
      bank_q   <= bank_d;
      shadow_q <= shadow_d;
      outA_q   <= outA_d;
      outB_q   <= outB_d;
      svld_q   <= svld_d;
    end
  end

  assign outDataA    = outA_q;
  assign outDataB    = outB_q;
  assign shadowValid = svld_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: drives two reg_bank instances (DEPTH=16 and DEPTH=12) with the
// same directed and random stimulus; a behavioural model queues the expected
// outputs and a monitor compares them one edge later.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        writeReg = 1'b0;
  logic [3:0]  writeAddr = '0;
  logic [15:0] writeData = '0;
  logic [3:0]  readAddrA = '0;
  logic [3:0]  readAddrB = '0;
  logic        save = 1'b0;
  logic        restore = 1'b0;
  logic [15:0] outA0, outB0, outA1, outB1;
  logic        sv0, sv1;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b1)) dut16 (
    .clk(clk), .reset(reset), .writeReg(writeReg), .writeAddr(writeAddr),
    .writeData(writeData), .readAddrA(readAddrA), .readAddrB(readAddrB),
    .save(save), .restore(restore), .outDataA(outA0), .outDataB(outB0),
    .shadowValid(sv0)
  );

  reg_bank #(.WIDTH(16), .DEPTH(12), .ZERO_REG(1'b1)) dut12 (
    .clk(clk), .reset(reset), .writeReg(writeReg), .writeAddr(writeAddr),
    .writeData(writeData), .readAddrA(readAddrA), .readAddrB(readAddrB),
    .save(save), .restore(restore), .outDataA(outA1), .outDataB(outB1),
    .shadowValid(sv1)
  );

  typedef struct {
    logic [15:0] a [2];
    logic [15:0] b [2];
    logic        v [2];
  } exp_t;

  exp_t exp_q [$];

  // Reference model state, one copy per instance
  int          depth [2] = '{16, 12};
  logic [15:0] mbank [2][16];
  logic [15:0] mshad [2][16];
  logic        msv   [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
  endtask

  function automatic logic [15:0] mread(input int k, input logic [15:0] nb [16], input int addr);
    if (addr >= depth[k] || addr == 0) return 16'h0;
    return nb[addr];
  endfunction

  // Apply one cycle of inputs and push what the outputs must be after that edge
  task automatic step(input logic rst_n, input logic we, input logic [3:0] wa,
                      input logic [15:0] wd, input logic [3:0] ra, input logic [3:0] rb,
                      input logic sav, input logic rst);
    exp_t e;
    logic [15:0] nb [16];
    @(negedge clk);
    reset = rst_n; writeReg = we; writeAddr = wa; writeData = wd;
    readAddrA = ra; readAddrB = rb; save = sav; restore = rst;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) begin
          mbank[k][i] = 16'h0;
          mshad[k][i] = 16'h0;
        end
        msv[k] = 1'b0;
        e.a[k] = 16'h0; e.b[k] = 16'h0; e.v[k] = 1'b0;
      end else begin
        nb = (rst && msv[k]) ? mshad[k] : mbank[k];
        if (we && int'(wa) < depth[k] && wa != 0) nb[wa] = wd;
        mbank[k] = nb;
        if (rst) msv[k] = 1'b0;
        else if (sav) begin
          mshad[k] = nb;
          msv[k]   = 1'b1;
        end
        e.a[k] = mread(k, nb, int'(ra));
        e.b[k] = mread(k, nb, int'(rb));
        e.v[k] = msv[k];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [3:0] ra, input logic [3:0] rb);
    step(1'b1, 1'b0, 4'd0, 16'h0, ra, rb, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] wa, input logic [15:0] wd);
    step(1'b1, 1'b1, wa, wd, wa, wa, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are registered every edge, so compare one entry per edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("d16_outA", outA0, e.a[0]);
      chk("d16_outB", outB0, e.b[0]);
      chk("d16_shadowValid", {15'h0, sv0}, {15'h0, e.v[0]});
      chk("d12_outA", outA1, e.a[1]);
      chk("d12_outB", outB1, e.b[1]);
      chk("d12_shadowValid", {15'h0, sv1}, {15'h0, e.v[1]});
    end
  end

  initial begin
    int wait_cyc;
    // Reset clears everything, including a prior write
    step(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
    wr(4'd3, 16'hBEEF);
    step(1'b0, 1'b0, 4'd0, 16'h0, 4'd3, 4'd15, 1'b0, 1'b0);
    rd(4'd3, 4'd15);
    // Write-first bypass and the zero register
    wr(4'd5, 16'h1234);
    wr(4'd0, 16'hFFFF);
    rd(4'd0, 4'd5);
    // Save / restore
    wr(4'd1, 16'h0011);
    wr(4'd2, 16'h0022);
    step(1'b1, 1'b1, 4'd2, 16'h00AA, 4'd2, 4'd1, 1'b1, 1'b0);
    wr(4'd1, 16'h9999);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd1, 4'd2, 1'b0, 1'b1);
    rd(4'd2, 4'd1);
    // Restore with a same-cycle write
    wr(4'd4, 16'h0044);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd4, 4'd1, 1'b1, 1'b0);
    wr(4'd4, 16'h1111);
    wr(4'd3, 16'h3333);
    step(1'b1, 1'b1, 4'd4, 16'h7777, 4'd4, 4'd3, 1'b0, 1'b1);
    rd(4'd3, 4'd1);
    // Restore without a snapshot, then save+restore together
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd4, 4'd3, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd4, 4'd3, 1'b1, 1'b0);
    wr(4'd4, 16'h0000);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd4, 4'd3, 1'b1, 1'b1);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd4, 4'd3, 1'b0, 1'b1);
    // Out-of-range write/read (past DEPTH=12), then sweep all registers
    wr(4'd13, 16'h5555);
    for (int i = 0; i < 16; i++) rd(4'(i), 4'd13);
    // Reset in the middle of save/restore traffic
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd1, 4'd2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'd0, 16'h0, 4'd1, 4'd2, 1'b0, 1'b1);
    rd(4'd1, 4'd2);
    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 2) != 0),
           4'($urandom_range(0, 15)),
           16'($urandom),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 11) == 0));
    end
    @(negedge clk);
    writeReg = 1'b0; save = 1'b0; restore = 1'b0;
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
